camo_gate_array_keyed: RTL and testbench

//  Parametrised successor to the single MUX-camouflaged c17 gate. N_CELLS 2-input cells; each

---
 rtl/camo_pkg.sv | 29 ++
 rtl/camo_cell.sv | 13 +
 rtl/camo_gate_array_keyed.sv | 126 ++++++++++++
 tb/tb_camo_gate_array_keyed.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/camo_pkg.sv
// Shared types and the cell truth function for the keyed camouflaged gate array.
package camo_pkg;

  typedef enum logic [1:0] {
    FN_NAND = 2'b00,
    FN_XOR  = 2'b01,
    FN_NOR  = 2'b10,
    FN_XNOR = 2'b11
  } cell_fn_e;

  typedef enum logic [1:0] {
    ST_UNKEYED = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_FULL    = 2'd2,
    ST_ARMED   = 2'd3
  } key_state_e;

  function automatic logic camo_eval(input logic [1:0] sel, input logic a, input logic b);
    logic y;
    case (cell_fn_e'(sel))
      FN_NAND: y = ~(a & b);
      FN_XOR:  y = a ^ b;
      FN_NOR:  y = ~(a | b);
      default: y = ~(a ^ b);
    endcase
    return y;
  endfunction

endpackage

// File: rtl/camo_cell.sv
// One camouflaged 2-input cell; its function is chosen by a 2-bit key slice.
module camo_cell
  import camo_pkg::*;
(
  input  logic [1:0] sel,
  input  logic       a,
  input  logic       b,
  output logic       y
);

  assign y = camo_eval(sel, a, b);

endmodule

// File: rtl/camo_gate_array_keyed.sv
// Keyed camouflaged cell array: serial key shifter, atomic commit into a shadow key,
// and PIPE registered output stages gated until a key is armed.
//
// state      | meaning
// UNKEYED    | no key ever committed since reset; accepting key bits
// SHIFT      | key load in progress; counter holds bits received
// FULL       | shifter holds KEY_W bits; key_ready low, waiting for commit
// ARMED      | active key valid; a new load may start without disarming
module camo_gate_array_keyed
  import camo_pkg::*;
#(
  parameter int N_CELLS = 8,
  parameter int PIPE    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_bit,
  input  logic               key_valid,
  output logic               key_ready,
  input  logic               key_commit,
  output logic               key_armed,
  input  logic               in_valid,
  input  logic [N_CELLS-1:0] in_a,
  input  logic [N_CELLS-1:0] in_b,
  output logic               out_valid,
  output logic [N_CELLS-1:0] out_y
);

  localparam int KEY_W = 2 * N_CELLS;
  localparam int CNT_W = $clog2(KEY_W + 1);

  key_state_e       state, state_nxt;
  logic [KEY_W-1:0] shifter, shifter_nxt;
  logic [KEY_W-1:0] active_key, active_key_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             armed_nxt;
  logic             xfer;
  logic [N_CELLS-1:0] cell_y;
  logic             accept;

  assign key_ready = (state != ST_FULL);
  assign xfer      = key_valid && key_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_UNKEYED;
      shifter    <= '0;
      active_key <= '0;
      cnt        <= '0;
      key_armed  <= 1'b0;
    end else begin
      state      <= state_nxt;
      shifter    <= shifter_nxt;
      active_key <= active_key_nxt;
      cnt        <= cnt_nxt;
      key_armed  <= armed_nxt;
    end
  end

  // First bit received ends up in bit 0 (LSB of cell 0) once KEY_W bits have arrived.
  always_comb begin
    state_nxt      = state;
    shifter_nxt    = shifter;
    active_key_nxt = active_key;
    cnt_nxt        = cnt;
    armed_nxt      = key_armed;
    case (state)
      ST_UNKEYED, ST_ARMED: begin
        if (xfer) begin
          shifter_nxt = {key_bit, shifter[KEY_W-1:1]};
          cnt_nxt     = CNT_W'(1);
          state_nxt   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (xfer) begin
          shifter_nxt = {key_bit, shifter[KEY_W-1:1]};
          cnt_nxt     = cnt + 1'b1;
          if (cnt + 1'b1 == CNT_W'(KEY_W)) state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (key_commit) begin
          active_key_nxt = shifter;
          cnt_nxt        = '0;
          armed_nxt      = 1'b1;
          state_nxt      = ST_ARMED;
        end
      end
      default: state_nxt = ST_UNKEYED;
    endcase
  end

  for (genvar i = 0; i < N_CELLS; i++) begin : g_cell
    camo_cell u_cell (
      .sel (active_key[2*i+1:2*i]),
      .a   (in_a[i]),
      .b   (in_b[i]),
      .y   (cell_y[i])
    );
  end

  assign accept = in_valid && key_armed;

  logic [PIPE-1:0]              v_q;
  logic [PIPE-1:0][N_CELLS-1:0] y_q;

  // Result registers only load on valid samples so out_y stays 0 until the first armed sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= '0;
      y_q <= '0;
    end else begin
      v_q[0] <= accept;
      if (accept) y_q[0] <= cell_y;
      for (int s = 1; s < PIPE; s++) begin
        v_q[s] <= v_q[s-1];
        if (v_q[s-1]) y_q[s] <= y_q[s-1];
      end
    end
  end

  assign out_valid = v_q[PIPE-1];
  assign out_y     = y_q[PIPE-1];

endmodule

// File: tb/tb_camo_gate_array_keyed.sv
// Randomized bench for camo_gate_array_keyed against a queue-based key/data reference model.
module tb_camo_gate_array_keyed;

  localparam int N  = 4;
  localparam int P  = 2;
  localparam int KW = 2 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_bit = 1'b0;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic         key_commit = 1'b0;
  logic         key_armed;
  logic         in_valid = 1'b0;
  logic [N-1:0] in_a = '0;
  logic [N-1:0] in_b = '0;
  logic         out_valid;
  logic [N-1:0] out_y;

  camo_gate_array_keyed #(.N_CELLS(N), .PIPE(P)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_bit    (key_bit),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_commit (key_commit),
    .key_armed  (key_armed),
    .in_valid   (in_valid),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_y      (out_y)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  string phase = "reset";

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s/%s: got 0x%0h, expected 0x%0h at %0t", phase, tag, obs, exp, $time);
  endtask

  // Reference model: pending key bits in a queue, committed key as a bit array,
  // and a history of accepted samples of which the P-th most recent is on the output.
  typedef struct { bit v; logic [N-1:0] y; } smp_t;
  bit   sq[$];
  bit   mk[KW];
  bit   m_armed = 1'b0;
  smp_t hist[$];

  function automatic logic [N-1:0] ref_eval(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) begin
      case ({mk[2*i+1], mk[2*i]})
        2'b00:   r[i] = !(a[i] && b[i]);
        2'b01:   r[i] = a[i] != b[i];
        2'b10:   r[i] = !(a[i] || b[i]);
        default: r[i] = a[i] == b[i];
      endcase
    end
    return r;
  endfunction

  task automatic step();
    smp_t s;
    smp_t e;
    @(posedge clk);
    if (!rst_n) begin
      sq.delete();
      hist.delete();
      m_armed = 1'b0;
    end else begin
      s.v = m_armed && in_valid;
      s.y = ref_eval(in_a, in_b);
      hist.push_front(s);
      if (hist.size() > P) void'(hist.pop_back());
      if (key_commit && sq.size() == KW) begin
        for (int i = 0; i < KW; i++) mk[i] = sq[i];
        sq.delete();
        m_armed = 1'b1;
      end else if (key_valid && sq.size() < KW) begin
        sq.push_back(key_bit);
      end
    end
    #1;
    chk("key_ready", key_ready, sq.size() < KW);
    chk("key_armed", key_armed, m_armed);
    e.v = 1'b0;
    e.y = '0;
    if (hist.size() == P) e = hist[P-1];
    chk("out_valid", out_valid, e.v);
    if (e.v) chk("out_y", out_y, e.y);
    if (!m_armed) chk("out_y_gated", out_y, '0);
  endtask

  task automatic rand_data();
    in_valid = 1'($urandom_range(0, 1));
    in_a     = N'($urandom);
    in_b     = N'($urandom);
  endtask

  task automatic load_key(input logic [KW-1:0] k, input bit with_data);
    for (int i = 0; i < KW; i++) begin
      key_valid = 1'b1;
      key_bit   = k[i];
      if (with_data) rand_data();
      step();
    end
    key_valid = 1'b0;
  endtask

  task automatic commit(input bit with_data);
    key_commit = 1'b1;
    if (with_data) rand_data();
    step();
    key_commit = 1'b0;
  endtask

  initial begin
    logic [KW-1:0] k;

    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    phase = "pre_arm";
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_a = N'($urandom);
      in_b = N'($urandom);
      step();
    end

    phase = "load_e4";
    k = 8'hE4;
    load_key(k, 1'b1);

    phase = "full_drop";
    for (int i = 0; i < 3; i++) begin
      key_valid = 1'b1;
      key_bit = 1'($urandom);
      step();
    end
    key_valid = 1'b1;
    phase = "commit_e4";
    commit(1'b0);
    key_valid = 1'b0;

    phase = "directed";
    in_valid = 1'b1;
    in_a = 4'b1010;
    in_b = 4'b0110;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < P + 1; i++) step();

    phase = "stream";
    for (int i = 0; i < 20; i++) begin rand_data(); step(); end

    phase = "reload";
    for (int i = 0; i < 40 && sq.size() < KW; i++) begin
      key_valid = 1'($urandom_range(0, 1));
      key_bit = 1'($urandom);
      rand_data();
      step();
    end
    key_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin rand_data(); step(); end
    commit(1'b1);
    for (int i = 0; i < 10; i++) begin rand_data(); step(); end

    phase = "reset_mid_shift";
    for (int i = 0; i < 3; i++) begin
      key_valid = 1'b1;
      key_bit = 1'($urandom);
      in_valid = 1'b1;
      step();
    end
    key_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    k = 8'h1B;
    load_key(k, 1'b1);
    commit(1'b1);
    for (int i = 0; i < 15; i++) begin rand_data(); step(); end

    phase = "soak";
    for (int i = 0; i < 500; i++) begin
      key_valid  = 1'($urandom_range(0, 1));
      key_bit    = 1'($urandom);
      key_commit = ($urandom_range(0, 7) == 0);
      rst_n      = ($urandom_range(0, 149) != 0);
      rand_data();
      step();
    end
    rst_n = 1'b1;
    key_valid = 1'b0;
    key_commit = 1'b0;
    in_valid = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
